// File: rtl/bird_motion_if.sv
// ---------------------------------------------------------------------------
// bird_motion_if
//   Groups the game-control inputs and the bird state outputs of the bird
//   motion block into one bundle.
//
//   Signals:
//     flap      - single-cycle flap pulse (never high two cycles in a row)
//     tick      - single-cycle frame-step enable pacing all motion
//     collide   - level, high while the bird overlaps a pipe
//     bird_y    - current bird row, 0 = top, ROWS-1 = bottom
//     playing   - high while the bird is flying
//     game_over - high once the bird has died
//
//   Modports:
//     master - drives flap/tick/collide, observes the bird state
//     slave  - the bird motion block itself
// ---------------------------------------------------------------------------
interface bird_motion_if #(
  parameter int ROWS = 16
);

  localparam int YW = $clog2(ROWS);

  logic          flap;
  logic          tick;
  logic          collide;
  logic [YW-1:0] bird_y;
  logic          playing;
  logic          game_over;

  modport master (
    output flap,
    output tick,
    output collide,
    input  bird_y,
    input  playing,
    input  game_over
  );

  modport slave (
    input  flap,
    input  tick,
    input  collide,
    output bird_y,
    output playing,
    output game_over
  );

endinterface

// File: rtl/bird_motion.sv
// ---------------------------------------------------------------------------
// bird_motion
//   Vertical motion controller for the bird in a flappy-style game.
//   Three states: IDLE (waiting at START_Y), FLY (rising after flaps,
//   falling one row every FALL_DIV ticks) and DEAD (frozen until a flap).
//
//   Parameters:
//     ROWS       - number of display rows (row 0 is the top)
//     START_Y    - bird row while idle
//     RISE_STEPS - ticks of upward motion granted per flap
//     FALL_DIV   - ticks per one-row fall (1..15)
//
//   Ports:
//     clk   - system clock, all state updates on its rising edge
//     reset - synchronous, active-high reset
//     bus   - bird_motion_if slave: flap/tick/collide in,
//             bird_y/playing/game_over out (all outputs registered)
// ---------------------------------------------------------------------------
module bird_motion #(
  parameter int ROWS       = 16,
  parameter int START_Y    = 7,
  parameter int RISE_STEPS = 3,
  parameter int FALL_DIV   = 2
) (
  input  logic         clk,
  input  logic         reset,
  bird_motion_if.slave bus
);

  localparam int YW = $clog2(ROWS);

  localparam logic [YW-1:0] Y_START   = YW'(START_Y);
  localparam logic [YW-1:0] Y_FLOOR   = YW'(ROWS - 1);
  localparam logic [3:0]    RISE_LOAD = 4'(RISE_STEPS);
  localparam logic [3:0]    FALL_LAST = 4'(FALL_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FLY  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [YW-1:0] y_q;
  logic [YW-1:0] y_d;
  logic [3:0]    rise_q;
  logic [3:0]    rise_d;
  logic [3:0]    fall_q;
  logic [3:0]    fall_d;
  logic          playing_q;
  logic          game_over_q;

  // State register. The status flags are registered from the next state so
  // they change on the same edge as the state itself, keeping every output
  // free of combinational paths from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      y_q         <= Y_START;
      rise_q      <= '0;
      fall_q      <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      playing_q   <= (state_d == FLY);
      game_over_q <= (state_d == DEAD);
    end
  end

  // Next-state and motion logic. Within FLY the priority is
  // collide > flap > tick; a flap swallows a coincident tick.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    rise_d  = rise_q;
    fall_d  = fall_q;

    case (state_q)
      IDLE: begin
        y_d = Y_START;
        if (bus.flap) begin
          state_d = FLY;
          rise_d  = RISE_LOAD;
          fall_d  = '0;
        end
      end

      FLY: begin
        if (bus.collide) begin
          state_d = DEAD;
        end else if (bus.flap) begin
          rise_d = RISE_LOAD;
          fall_d = '0;
        end else if (bus.tick) begin
          if (rise_q != '0) begin
            // Hitting the ceiling forfeits the remaining rise.
            if (y_q == '0) begin
              rise_d = '0;
            end else begin
              y_d    = y_q - 1'b1;
              rise_d = rise_q - 1'b1;
            end
          end else if (fall_q >= FALL_LAST) begin
            // The >= keeps the divider from ever wrapping.
            fall_d = '0;
            if (y_q == Y_FLOOR) begin
              state_d = DEAD;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            fall_d = fall_q + 1'b1;
          end
        end
      end

      DEAD: begin
        if (bus.flap) begin
          state_d = IDLE;
          y_d     = Y_START;
          rise_d  = '0;
          fall_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        y_d     = Y_START;
        rise_d  = '0;
        fall_d  = '0;
      end
    endcase
  end

  assign bus.bird_y    = y_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_bird_motion.sv
// ---------------------------------------------------------------------------
// tb_bird_motion
//   Self-checking bench for bird_motion: a directed vector table covering
//   the scripted game scenarios, then randomized stimulus compared against
//   a behavioural model of the bird.
// ---------------------------------------------------------------------------
module tb_bird_motion;

  localparam int ROWS       = 16;
  localparam int START_Y    = 7;
  localparam int RISE_STEPS = 3;
  localparam int FALL_DIV   = 2;
  localparam int YW         = $clog2(ROWS);
  localparam int NRAND      = 3000;

  typedef struct {
    logic r;
    logic f;
    logic t;
    logic c;
    int   y;
    logic p;
    logic o;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  // Model state: mode 0 = idle, 1 = flying, 2 = dead.
  int mMode;
  int mY;
  int mRise;
  int mFall;

  always #5 clk = ~clk;

  bird_motion_if #(.ROWS(ROWS)) bus();

  bird_motion #(
    .ROWS(ROWS),
    .START_Y(START_Y),
    .RISE_STEPS(RISE_STEPS),
    .FALL_DIV(FALL_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic addVec(input logic r, input logic f, input logic t, input logic c,
                        input int y, input logic p, input logic o);
    vec_t v;
    v.r = r; v.f = f; v.t = t; v.c = c;
    v.y = y; v.p = p; v.o = o;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge, outputs are sampled 1 ns after the
  // rising edge that consumed them.
  task automatic applyStimulus(input logic r, input logic f, input logic t, input logic c);
    @(negedge clk);
    reset       = r;
    bus.flap    = f;
    bus.tick    = t;
    bus.collide = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx,
                             input int y, input logic p, input logic o);
    logic [YW-1:0] ey;
    ey = YW'(y);
    checks++;
    if (bus.bird_y !== ey) begin
      fails++;
      $display("[TB] FAIL %s[%0d] bird_y: got %0d, expected %0d", tag, idx, bus.bird_y, ey);
    end
    checks++;
    if (bus.playing !== p) begin
      fails++;
      $display("[TB] FAIL %s[%0d] playing: got %b, expected %b", tag, idx, bus.playing, p);
    end
    checks++;
    if (bus.game_over !== o) begin
      fails++;
      $display("[TB] FAIL %s[%0d] game_over: got %b, expected %b", tag, idx, bus.game_over, o);
    end
  endtask

  // Reference bird: the fall divider is treated as "ticks spent falling so
  // far", a row is dropped once FALL_DIV of them have accumulated.
  task automatic modelStep(input logic r, input logic f, input logic t, input logic c);
    if (r) begin
      mMode = 0; mY = START_Y; mRise = 0; mFall = 0;
    end else if (mMode == 0) begin
      mY = START_Y;
      if (f) begin
        mMode = 1; mRise = RISE_STEPS; mFall = 0;
      end
    end else if (mMode == 2) begin
      if (f) begin
        mMode = 0; mY = START_Y; mRise = 0; mFall = 0;
      end
    end else if (c) begin
      mMode = 2;
    end else if (f) begin
      mRise = RISE_STEPS; mFall = 0;
    end else if (t) begin
      if (mRise > 0) begin
        if (mY == 0) mRise = 0;
        else begin
          mY = mY - 1;
          mRise = mRise - 1;
        end
      end else begin
        mFall = mFall + 1;
        if (mFall >= FALL_DIV) begin
          mFall = 0;
          if (mY == ROWS - 1) mMode = 2;
          else mY = mY + 1;
        end
      end
    end
  endtask

  initial begin
    logic r;
    logic f;
    logic t;
    logic c;
    logic prevFlap;

    reset       = 1'b1;
    bus.flap    = 1'b0;
    bus.tick    = 1'b0;
    bus.collide = 1'b0;

    // Reset, then ticks alone leave the bird parked at START_Y.
    addVec(1, 0, 0, 0, 7, 0, 0);
    for (int i = 0; i < 10; i++) addVec(0, 0, 1, 0, 7, 0, 0);

    // Flap from idle, rise three rows, then fall every second tick.
    addVec(0, 1, 0, 0, 7, 1, 0);
    addVec(0, 0, 1, 0, 6, 1, 0);
    addVec(0, 0, 1, 0, 5, 1, 0);
    addVec(0, 0, 1, 0, 4, 1, 0);
    addVec(0, 0, 1, 0, 4, 1, 0);
    addVec(0, 0, 1, 0, 5, 1, 0);
    addVec(0, 0, 1, 0, 5, 1, 0);
    addVec(0, 0, 1, 0, 6, 1, 0);

    // Climb to row 1; an idle cycle in flight changes nothing.
    addVec(0, 1, 0, 0, 6, 1, 0);
    addVec(0, 0, 1, 0, 5, 1, 0);
    addVec(0, 0, 1, 0, 4, 1, 0);
    addVec(0, 0, 1, 0, 3, 1, 0);
    addVec(0, 0, 0, 0, 3, 1, 0);
    addVec(0, 1, 0, 0, 3, 1, 0);
    addVec(0, 0, 1, 0, 2, 1, 0);
    addVec(0, 0, 1, 0, 1, 1, 0);

    // Ceiling clamp from row 1, then resume falling.
    addVec(0, 1, 0, 0, 1, 1, 0);
    addVec(0, 0, 1, 0, 0, 1, 0);
    addVec(0, 0, 1, 0, 0, 1, 0);
    addVec(0, 0, 1, 0, 0, 1, 0);
    addVec(0, 0, 1, 0, 1, 1, 0);
    addVec(0, 0, 1, 0, 1, 1, 0);
    addVec(0, 0, 1, 0, 2, 1, 0);
    for (int k = 3; k < ROWS; k++) begin
      addVec(0, 0, 1, 0, k - 1, 1, 0);
      addVec(0, 0, 1, 0, k, 1, 0);
    end

    // Floor death, dead state ignores tick/collide, flap returns to idle.
    addVec(0, 0, 1, 0, 15, 1, 0);
    addVec(0, 0, 1, 0, 15, 0, 1);
    addVec(0, 0, 1, 1, 15, 0, 1);
    addVec(0, 0, 0, 0, 15, 0, 1);
    addVec(0, 1, 0, 0, 7, 0, 0);
    addVec(0, 0, 1, 1, 7, 0, 0);

    // Collide beats a coincident flap and tick.
    addVec(0, 1, 0, 0, 7, 1, 0);
    addVec(0, 0, 1, 0, 6, 1, 0);
    addVec(0, 1, 1, 1, 6, 0, 1);
    addVec(0, 0, 0, 0, 6, 0, 1);
    addVec(0, 1, 0, 0, 7, 0, 0);
    addVec(0, 0, 0, 0, 7, 0, 0);

    // Reset mid-flight at row 3 discards the inputs of that cycle.
    addVec(0, 1, 0, 0, 7, 1, 0);
    addVec(0, 0, 1, 0, 6, 1, 0);
    addVec(0, 0, 1, 0, 5, 1, 0);
    addVec(0, 0, 1, 0, 4, 1, 0);
    addVec(0, 1, 0, 0, 4, 1, 0);
    addVec(0, 0, 1, 0, 3, 1, 0);
    addVec(1, 1, 1, 1, 7, 0, 0);
    addVec(0, 0, 1, 0, 7, 0, 0);

    // Reset also clears the dead state.
    addVec(0, 1, 0, 0, 7, 1, 0);
    addVec(0, 0, 0, 1, 7, 0, 1);
    addVec(1, 0, 1, 1, 7, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].t, vecs[i].c);
      checkOutput("vec", i, vecs[i].y, vecs[i].p, vecs[i].o);
    end

    // Randomized play against the behavioural model.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    modelStep(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rand", -1, mY, 1'b0, 1'b0);
    prevFlap = 1'b0;
    for (int i = 0; i < NRAND; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = !prevFlap && ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 49) == 0);
      prevFlap = f;
      applyStimulus(r, f, t, c);
      modelStep(r, f, t, c);
      checkOutput("rand", i, mY, (mMode == 1), (mMode == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
